// File: rtl/tile_flusher_if.sv
// ---------------------------------------------------------------------------
// tile_flusher_if
//   Write port from the tile flusher to the frame-buffer memory writer.
//   A pixel moves when wrValid & wrReady are both high at a rising clock edge.
//
//   wrAddr  [addrWidth-1:0]  linear screen address of the pixel
//   wrData  [15:0]           RGB565 colour
//   wrValid                  pixel on wrAddr/wrData is offered
//   wrReady                  memory writer can take the pixel this cycle
//
//   master : the flusher (drives address/data/valid, samples ready)
//   slave  : the memory writer
// ---------------------------------------------------------------------------
interface tile_flusher_if #(
  parameter int addrWidth = 19
);
  logic [addrWidth-1:0] wrAddr;
  logic [15:0]          wrData;
  logic                 wrValid;
  logic                 wrReady;

  modport master (output wrAddr, output wrData, output wrValid, input wrReady);
  modport slave  (input wrAddr, input wrData, input wrValid, output wrReady);
endinterface

// File: rtl/tile_flusher.sv
// ---------------------------------------------------------------------------
// tile_flusher
//   Reader side of the double-buffered colour tiles filled by the pixel
//   shader. A start request latches which tile is finished and where it sits
//   on screen, then streams its tileDim*tileDim RGB565 pixels (x fastest,
//   then y) to the frame-buffer writer. Pixels that fall off the right or
//   bottom screen edge are skipped at one pixel per cycle without a write.
//
//   Optional feature macro: TILE_FLUSH_CHECKSUM_EN
//     defined   -> flushChecksum accumulates wrData of every transfer
//                  (cleared in LATCH, final while doneFlushing is high)
//     undefined -> flushChecksum is tied to 0
//
// Ports
//   BOARD_CLK      clock, all state on rising edge
//   RESET          asynchronous active-high reset
//   startFlush     start request, only looked at while idle
//   flushTileID    0 -> cBufferTile0, 1 -> cBufferTile1
//   tileOffsetX/Y  screen position of tile pixel [0][0]
//   cBufferTile0/1 colour tiles, indexed [x][y]
//   wr             pixel write port (master side)
//   flushBusy      high from LATCH through DONE
//   doneFlushing   one-cycle pulse once the whole tile has been streamed
//   flushChecksum  sum of transferred pixels (see macro above)
// ---------------------------------------------------------------------------
module tile_flusher #(
  parameter int tileDim      = 8,
  parameter int screenWidth  = 640,
  parameter int screenHeight = 480,
  parameter int addrWidth    = 19
) (
  input  logic                                   BOARD_CLK,
  input  logic                                   RESET,
  input  logic                                   startFlush,
  input  logic                                   flushTileID,
  input  logic [9:0]                             tileOffsetX,
  input  logic [9:0]                             tileOffsetY,
  input  logic [tileDim-1:0][tileDim-1:0][15:0]  cBufferTile0,
  input  logic [tileDim-1:0][tileDim-1:0][15:0]  cBufferTile1,
  tile_flusher_if.master                         wr,
  output logic                                   flushBusy,
  output logic                                   doneFlushing,
  output logic [15:0]                            flushChecksum
);

  localparam int CW = (tileDim > 1) ? $clog2(tileDim) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(tileDim - 1);

  typedef enum logic [1:0] {IDLE, LATCH, SEND, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  x_q, x_d;
  logic [CW-1:0]  y_q, y_d;

  logic           tile_id_q;
  logic [9:0]     off_x_q;
  logic [9:0]     off_y_q;

  // Current pixel geometry, derived from the scan position and latched offsets
  logic [10:0]          px, py;
  logic                 pix_clip;
  logic                 pix_last;
  logic [addrWidth-1:0] pix_addr;
  logic [15:0]          pix_data;

  logic                 wr_valid;
  logic [addrWidth-1:0] wr_addr;
  logic [15:0]          wr_data;

  assign px       = {1'b0, off_x_q} + 11'(x_q);
  assign py       = {1'b0, off_y_q} + 11'(y_q);
  assign pix_clip = (px >= 11'(screenWidth)) || (py >= 11'(screenHeight));
  assign pix_last = (x_q == LAST_IDX) && (y_q == LAST_IDX);
  // Address wraps modulo 2^addrWidth by truncation
  assign pix_addr = addrWidth'(32'(py) * 32'(screenWidth) + 32'(px));
  assign pix_data = tile_id_q ? cBufferTile1[x_q][y_q] : cBufferTile0[x_q][y_q];

  // -------------------------------------------------------------------------
  // State register (FSM state plus scan position)
  // -------------------------------------------------------------------------
  always_ff @(posedge BOARD_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (startFlush) state_d = LATCH;
      end
      LATCH: begin
        x_d     = '0;
        y_d     = '0;
        state_d = SEND;
      end
      SEND: begin
        // A clipped pixel is skipped unconditionally; a visible one waits
        // for the writer. Holding x/y while stalled keeps addr/data stable.
        if (pix_clip || wr.wrReady) begin
          if (pix_last) begin
            state_d = DONE;
          end else if (x_q == LAST_IDX) begin
            x_d = '0;
            y_d = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    flushBusy    = (state_q != IDLE);
    doneFlushing = (state_q == DONE);
    wr_valid     = (state_q == SEND) && !pix_clip;
    // Bus reads zero whenever nothing is offered
    wr_addr      = wr_valid ? pix_addr : '0;
    wr_data      = wr_valid ? pix_data : '0;
  end

  assign wr.wrValid = wr_valid;
  assign wr.wrAddr  = wr_addr;
  assign wr.wrData  = wr_data;

  // -------------------------------------------------------------------------
  // Request capture. Taken on the edge that accepts the start, so the tile
  // select and offsets are already settled while in LATCH and any later
  // change on the ports cannot disturb the flush in progress.
  // -------------------------------------------------------------------------
  always_ff @(posedge BOARD_CLK or posedge RESET) begin
    if (RESET) begin
      tile_id_q <= 1'b0;
      off_x_q   <= '0;
      off_y_q   <= '0;
    end else if (state_q == IDLE && startFlush) begin
      tile_id_q <= flushTileID;
      off_x_q   <= tileOffsetX;
      off_y_q   <= tileOffsetY;
    end
  end

`ifdef TILE_FLUSH_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge BOARD_CLK or posedge RESET) begin
    if (RESET) begin
      csum_q <= '0;
    end else if (state_q == LATCH) begin
      csum_q <= '0;
    end else if (wr_valid && wr.wrReady) begin
      csum_q <= csum_q + wr_data;
    end
  end

  assign flushChecksum = csum_q;
`else
  assign flushChecksum = '0;
`endif

endmodule
